// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
//
// Holds the loader state encoding, the instruction word width, the op-field
// slice and the default halt opcode. Imported by imem_loader and word_packer.
// Optional feature macro used by the loader: IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    // Op field of an instruction word, bits 31:26.
    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int OP_W  = OP_HI - OP_LO + 1;

    localparam logic [OP_W-1:0] HALT_OP_DEFAULT = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

    function automatic logic [OP_W-1:0] op_field(input logic [WORD_W-1:0] w);
        return w[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - little-endian byte-to-word assembly register
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   restart assembly at byte 0 and zero the word
//   accept     in   byte_data is taken this cycle
//   byte_data  in   8-bit input byte, least significant byte first
//   word       out  32-bit assembly register
//   word_full  out  the byte taken this cycle completes the word
module word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [1:0] byte_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (accept) begin
            word[BYTE_W*byte_idx +: BYTE_W] <= byte_data;
            byte_idx                         <= byte_idx + 2'd1;
        end
    end

    // Combinational so the FSM can leave COLLECT on the same edge that
    // captures the fourth byte.
    assign word_full = accept && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a byte-wise program into instruction memory, then releases the core
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing 32-bit checksum word).
//
// Ports:
//   sysclk      in   system clock, rising edge
//   cpu_resetn  in   asynchronous active-low reset
//   load_start  in   pulse; begins a load when idle or done
//   byte_valid  in   byte_data valid
//   byte_data   in   program byte, least significant byte of each word first
//   byte_ready  out  loader accepts a byte this cycle
//   imem_we     out  instruction memory write strobe, one cycle per word
//   imem_addr   out  instruction memory word address
//   imem_wdata  out  word to write
//   busy        out  load in progress
//   cpu_run     out  load finished without error; releases the core
//   word_count  out  words written in the current or last load
//   err         out  overflow (or checksum) error, sticky until next load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int              IMEM_AW = 8,
    parameter logic [OP_W-1:0] HALT_OP = HALT_OP_DEFAULT
) (
    input  logic               sysclk,
    input  logic               cpu_resetn,
    input  logic               load_start,
    input  logic               byte_valid,
    input  logic [BYTE_W-1:0]  byte_data,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [WORD_W-1:0]  imem_wdata,
    output logic               busy,
    output logic               cpu_run,
    output logic [IMEM_AW:0]   word_count,
    output logic               err
);

    state_t state;
    state_t state_next;

    logic [IMEM_AW-1:0] addr;
    logic [WORD_W-1:0]  word;
    logic               word_full;
    logic               accept;
    logic               clear;
    logic               start;
    logic               is_halt;
    logic               addr_last;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum;
    logic [WORD_W-1:0] check_word;

    // The checksum word is compared as its last byte arrives, before the
    // packer register has captured it.
    assign check_word = {byte_data, word[WORD_W-BYTE_W-1:0]};
`endif

    assign accept    = byte_valid && byte_ready;
    assign start     = load_start && ((state == ST_IDLE) || (state == ST_DONE));
    assign is_halt   = (op_field(word) == HALT_OP);
    assign addr_last = &addr;

    word_packer u_word_packer (
        .clk       (sysclk),
        .rst_n     (cpu_resetn),
        .clear     (clear),
        .accept    (accept),
        .byte_data (byte_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        clear      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    clear      = 1'b1;
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (word_full) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
                clear   = 1'b1;
                if (is_halt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_DONE;
`endif
                end else if (addr_last) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_COLLECT;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (word_full) begin
                    state_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (load_start) begin
                    clear      = 1'b1;
                    state_next = ST_COLLECT;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            addr       <= '0;
            word_count <= '0;
            err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else if (start) begin
            addr       <= '0;
            word_count <= '0;
            err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else if (state == ST_WRITE) begin
            // At most 2^IMEM_AW writes per load, so this never wraps.
            word_count <= word_count + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= sum + word;
`endif
            if (!is_halt) begin
                if (addr_last) begin
                    err <= 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        else if ((state == ST_CHECK) && word_full && (check_word != sum)) begin
            err <= 1'b1;
        end
`endif
    end

    assign imem_addr  = addr;
    assign imem_wdata = word;
    assign cpu_run    = (state == ST_DONE) && !err;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer end of the instruction-fetch path: streams a program into instruction memory through its write port, then releases the core.
- Accepts a byte stream (valid/ready), packs little-endian 32-bit words and writes them to consecutive word addresses from 0.
- Loading ends on the halt word (op field 6'b111111). After that, cpu_run is asserted and drives the core's cpu_resetn gating.
- Sits between the board-side byte source and processor/fetch.

Parameters:
IMEM_AW, 8, instruction memory word-address width (2^IMEM_AW words)
HALT_OP, 6'b111111, op field (bits 31:26) that terminates the load

Ports:
sysclk  in  1  system clock, rising edge
cpu_resetn  in  1  asynchronous active-low reset
load_start  in  1  single-cycle pulse; begins a load (honoured only in IDLE or DONE)
byte_valid  in  1  byte_data valid
byte_data  in  8  program byte, least significant byte of each word first
byte_ready  out  1  loader accepts byte this cycle
imem_we  out  1  instruction memory write strobe, one cycle per word
imem_addr  out  IMEM_AW  word address
imem_wdata  out  32  word to write
busy  out  1  high in COLLECT/WRITE (and CHECK when enabled)
cpu_run  out  1  high in DONE without error; core held in reset otherwise
word_count  out  IMEM_AW+1  words written in the current or last load
err  out  1  overflow (or checksum) error, sticky until next load_start

Behaviour:
- Reset (async, cpu_resetn=0): state=IDLE. All outputs 0, including word buffer, byte index and address. Reset mid-load abandons the load; the partially written memory is left as is.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: byte_ready=0. load_start -> COLLECT.
  - On entry: addr=0, byte_idx=0, word_count=0, err=0, cpu_run=0.
- COLLECT: byte_ready=1.
  - On byte_valid&byte_ready, byte_data goes to word[8*byte_idx+:8] and byte_idx increments.
  - The 4th accepted byte moves the FSM to WRITE on the next edge.
  - byte_valid with byte_ready=0 is ignored; the source must hold the byte.
- WRITE: exactly one cycle. byte_ready=0, imem_we=1, imem_wdata=word, imem_addr=addr, word_count increments.
  - If word[31:26]==HALT_OP: next state DONE. The halt word is itself written.
  - Else if addr is all ones: err=1, next state DONE, cpu_run stays 0.
  - Else: addr+1, byte_idx=0, next state COLLECT.
- Latency: the 4th byte is accepted at edge N; imem_we is high in cycle N+1. Best case is 5 cycles per word.
- DONE: byte_ready=0, busy=0. cpu_run=~err, held.
  - load_start -> IDLE-entry actions, then COLLECT next cycle. cpu_run drops in the same edge.
- load_start while busy is ignored.
- word_count saturates by construction (at most 2^IMEM_AW).

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- With the macro: a 32-bit wrapping sum of all written words, halt word included, is accumulated.
  - After the halt write the FSM enters CHECK and collects 4 more bytes (same packing); nothing is written.
  - Match -> DONE with cpu_run=1.
  - Mismatch -> DONE, err=1, cpu_run=0.
- Without the macro: the CHECK state and sum register are absent, and the halt write goes straight to DONE.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, COLLECT, WRITE, CHECK, DONE)
  - the HALT_OP default and the op-field slice constants (31:26)
  - the word width (32)
- One sub-module, word_packer: the byte index counter plus the 32-bit assembly register, with a clear input and a word_full output. The FSM, addressing and checksum stay in imem_loader.

Test Plan:
1. Reset mid-COLLECT after 2 bytes -> all outputs 0, state IDLE. A subsequent load writes addr 0 from its first byte.
2. load_start; bytes 20,00,09,00 then 00,00,00,FC, each with byte_valid held -> imem_we at addr 0 data 32'h00090020, then at addr 1 data 32'hFC000000 (halt). Result: cpu_run=1, word_count=2.
3. byte_valid toggling 1/0 with 3-cycle gaps -> identical memory image to scenario 2. No byte is lost or duplicated.
4. IMEM_AW=2, five non-halt words -> 4 writes at addrs 0..3, then err=1, cpu_run=0, word_count=4.
5. load_start pulsed during COLLECT -> ignored. load_start in DONE -> cpu_run falls the next cycle and addr restarts at 0.
6. With IMEM_LOADER_CHECKSUM_EN, scenario 2 followed by checksum 32'hFC090020 -> cpu_run=1. With checksum 32'hFC090021 -> err=1, cpu_run=0.
